// File: rtl/next_pc_unit.sv
// next_pc_unit: next-PC selection and bounded return-address stack.
// State updates on the falling edge of Clk (the same edge on which the PC
// register loads Next_PC). Clear_n is an asynchronous active-low reset.
// Optional build macro NEXTPC_STACK_WRAP_EN: when defined, a CALL on a full
// stack overwrites the oldest entry (circular stack) instead of faulting.
module next_pc_unit #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       Clk,
  input  logic       Clear_n,
  input  logic [7:0] PC,
  input  logic [2:0] Op,
  input  logic       Cond,
  input  logic [7:0] Target,
  input  logic       Stall,
  output logic [7:0] Next_PC,
  output logic [4:0] Depth,
  output logic       Err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef NEXTPC_STACK_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    OP_SEQ  = 3'd0,
    OP_BRC  = 3'd1,
    OP_JMP  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } op_e;

  logic [7:0]    stack_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_ptr_inc;
  logic [PW-1:0] top_ptr;
  logic [4:0]    count;
  logic [7:0]    pc_inc;
  logic [7:0]    top_data;
  logic          stack_empty;
  logic          stack_full;
  logic          is_call;
  logic          is_ret;
  logic          push_en;
  logic          pop_en;
  logic          err_set;

  // Stack pointer arithmetic modulo DEPTH; wr_ptr names the next free slot,
  // so the top entry always sits one slot below it (circularly).
  always_comb begin
    wr_ptr_inc  = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    top_ptr     = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - 1'b1;
    top_data    = stack_mem[top_ptr];
    stack_empty = (count == '0);
    stack_full  = (count == 5'(DEPTH));
    pc_inc      = PC + 8'd1;
  end

  // Decode which stack action (if any) the falling edge will perform.
  always_comb begin
    is_call = !Stall && (Op == OP_CALL);
    is_ret  = !Stall && (Op == OP_RET);
    push_en = is_call && (!stack_full || WRAP_EN);
    pop_en  = is_ret && !stack_empty;
    err_set = (is_ret && stack_empty) || (is_call && stack_full && !WRAP_EN);
  end

  // Combinational next-PC select; an 8-bit offset added modulo 256 is already
  // its own sign extension, so BRC is simply PC+1+Target.
  always_comb begin
    Next_PC = pc_inc;
    if (!Clear_n) begin
      Next_PC = 8'h00;
    end else if (Stall) begin
      Next_PC = PC;
    end else begin
      case (Op)
        OP_BRC:  Next_PC = Cond ? (pc_inc + Target) : pc_inc;
        OP_JMP:  Next_PC = Target;
        OP_CALL: Next_PC = Target;
        OP_RET:  Next_PC = stack_empty ? pc_inc : top_data;
        default: Next_PC = pc_inc;
      endcase
    end
  end

  // Stack entry storage; contents are don't-care after reset.
  always_ff @(negedge Clk) begin
    if (push_en) begin
      stack_mem[wr_ptr] <= pc_inc;
    end
  end

  // Pointer, occupancy and sticky fault flag.
  always_ff @(negedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      wr_ptr <= '0;
      count  <= '0;
      Err    <= 1'b0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr_inc;
        if (!stack_full) begin
          count <= count + 5'd1;
        end
      end else if (pop_en) begin
        wr_ptr <= top_ptr;
        count  <= count - 5'd1;
      end
      if (err_set) begin
        Err <= 1'b1;
      end
    end
  end

  assign Depth = count;

endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboard bench for next_pc_unit (DEPTH=4). Stimulus is applied just after
// each falling edge and the expected view is queued; the monitor pops and
// compares at the following rising edge, midway between active edges.
module tb_next_pc_unit;

  localparam logic [2:0] SEQ  = 3'd0;
  localparam logic [2:0] BRC  = 3'd1;
  localparam logic [2:0] JMP  = 3'd2;
  localparam logic [2:0] CALL = 3'd3;
  localparam logic [2:0] RET  = 3'd4;

`ifdef NEXTPC_STACK_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  // Err after the 5th CALL on a 4-deep stack
  localparam logic FE = WRAP ? 1'b0 : 1'b1;

  logic       Clk;
  logic       Clear_n;
  logic [7:0] PC;
  logic [2:0] Op;
  logic       Cond;
  logic [7:0] Target;
  logic       Stall;
  logic [7:0] Next_PC;
  logic [4:0] Depth;
  logic       Err;

  typedef struct {
    string      name;
    logic [7:0] npc;
    logic [4:0] dep;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  next_pc_unit #(.DEPTH(4)) dut (
    .Clk     (Clk),
    .Clear_n (Clear_n),
    .PC      (PC),
    .Op      (Op),
    .Cond    (Cond),
    .Target  (Target),
    .Stall   (Stall),
    .Next_PC (Next_PC),
    .Depth   (Depth),
    .Err     (Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic expect_now(input string nm, input logic [7:0] enpc,
                            input logic [4:0] ed, input logic ee);
    exp_t e;
    e.name = nm;
    e.npc  = enpc;
    e.dep  = ed;
    e.err  = ee;
    sb.push_back(e);
  endtask

  task automatic step(input string nm, input logic [7:0] pc, input logic [2:0] op,
                      input logic cond, input logic [7:0] tgt, input logic stl,
                      input logic [7:0] enpc, input logic [4:0] ed, input logic ee);
    @(negedge Clk);
    #1;
    PC = pc; Op = op; Cond = cond; Target = tgt; Stall = stl;
    expect_now(nm, enpc, ed, ee);
  endtask

  // Monitor: compare the DUT view against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (Next_PC !== e.npc) begin
          failures++;
          $display("FAIL %s Next_PC got=%02h want=%02h", e.name, Next_PC, e.npc);
        end
        checks++;
        if (Depth !== e.dep) begin
          failures++;
          $display("FAIL %s Depth got=%0d want=%0d", e.name, Depth, e.dep);
        end
        checks++;
        if (Err !== e.err) begin
          failures++;
          $display("FAIL %s Err got=%0b want=%0b", e.name, Err, e.err);
        end
      end
    end
  end

  initial begin
    Clear_n = 1'b0; PC = 8'hFF; Op = SEQ; Cond = 1'b0; Target = 8'h00; Stall = 1'b0;
    expect_now("rst_hold", 8'h00, 5'd0, 1'b0);

    @(negedge Clk);
    #1;
    Clear_n = 1'b1;
    expect_now("rst_seq", 8'h00, 5'd0, 1'b0);

    step("brc_taken",   8'h10, BRC,  1'b1, 8'hF0, 1'b0, 8'h01, 5'd0, 1'b0);
    step("brc_not",     8'h10, BRC,  1'b0, 8'hF0, 1'b0, 8'h11, 5'd0, 1'b0);
    step("jmp",         8'h40, JMP,  1'b0, 8'h5A, 1'b0, 8'h5A, 5'd0, 1'b0);
    step("op7_seq",     8'h41, 3'd7, 1'b1, 8'h77, 1'b0, 8'h42, 5'd0, 1'b0);
    step("call",        8'h20, CALL, 1'b0, 8'h80, 1'b0, 8'h80, 5'd0, 1'b0);
    step("ret",         8'h85, RET,  1'b0, 8'h00, 1'b0, 8'h21, 5'd1, 1'b0);
    step("after_ret",   8'h21, SEQ,  1'b0, 8'h00, 1'b0, 8'h22, 5'd0, 1'b0);
    step("stall_call",  8'h33, CALL, 1'b0, 8'h99, 1'b1, 8'h33, 5'd0, 1'b0);
    step("after_stall", 8'h34, SEQ,  1'b0, 8'h00, 1'b0, 8'h35, 5'd0, 1'b0);

    // Five CALLs into a 4-deep stack: return addresses 51,61,71,81,91
    step("call1", 8'h50, CALL, 1'b0, 8'hA0, 1'b0, 8'hA0, 5'd0, 1'b0);
    step("call2", 8'h60, CALL, 1'b0, 8'hA1, 1'b0, 8'hA1, 5'd1, 1'b0);
    step("call3", 8'h70, CALL, 1'b0, 8'hA2, 1'b0, 8'hA2, 5'd2, 1'b0);
    step("call4", 8'h80, CALL, 1'b0, 8'hA3, 1'b0, 8'hA3, 5'd3, 1'b0);
    step("call5", 8'h90, CALL, 1'b0, 8'hA4, 1'b0, 8'hA4, 5'd4, 1'b0);
    step("ret1", 8'hC0, RET, 1'b0, 8'h00, 1'b0, WRAP ? 8'h91 : 8'h81, 5'd4, FE);
    step("ret2", 8'hC1, RET, 1'b0, 8'h00, 1'b0, WRAP ? 8'h81 : 8'h71, 5'd3, FE);
    step("ret3", 8'hC2, RET, 1'b0, 8'h00, 1'b0, WRAP ? 8'h71 : 8'h61, 5'd2, FE);
    step("ret4", 8'hC3, RET, 1'b0, 8'h00, 1'b0, WRAP ? 8'h61 : 8'h51, 5'd1, FE);
    step("ret5_under", 8'hC4, RET, 1'b0, 8'h00, 1'b0, 8'hC5, 5'd0, FE);
    step("ret6_under", 8'hC5, RET, 1'b0, 8'h00, 1'b0, 8'hC6, 5'd0, 1'b1);
    step("err_sticky", 8'hD0, SEQ, 1'b0, 8'h00, 1'b0, 8'hD1, 5'd0, 1'b1);

    // Build Depth=3, then reset asynchronously between edges
    step("fill1", 8'h10, CALL, 1'b0, 8'h20, 1'b0, 8'h20, 5'd0, 1'b1);
    step("fill2", 8'h20, CALL, 1'b0, 8'h30, 1'b0, 8'h30, 5'd1, 1'b1);
    step("fill3", 8'h30, CALL, 1'b0, 8'h40, 1'b0, 8'h40, 5'd2, 1'b1);
    step("depth3", 8'h40, SEQ, 1'b0, 8'h00, 1'b0, 8'h41, 5'd3, 1'b1);

    @(negedge Clk);
    #1;
    PC = 8'h41; Op = SEQ; Stall = 1'b0;
    Clear_n = 1'b0;
    #1;
    Clear_n = 1'b1;
    expect_now("async_clr", 8'h42, 5'd0, 1'b0);

    step("ret_after_clr", 8'h50, RET, 1'b0, 8'h00, 1'b0, 8'h51, 5'd0, 1'b0);
    step("err_after_clr", 8'h60, SEQ, 1'b0, 8'h00, 1'b0, 8'h61, 5'd0, 1'b1);

    // Drain the scoreboard with a bounded wait
    for (int unsigned i = 0; i < 20 && sb.size() > 0; i++) begin
      @(negedge Clk);
    end
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
